caliptra_verilated_apb_driver: RTL and testbench



---
 rtl/caliptra_verilated_apb_driver_pkg.sv | 31 +++
 rtl/caliptra_verilated_apb_driver_if.sv | 42 ++++
 rtl/caliptra_verilated_apb_driver_req_fifo.sv | 37 +++
 rtl/caliptra_verilated_apb_driver.sv | 78 +++++++
 tb/tb_caliptra_verilated_apb_driver.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caliptra_verilated_apb_driver_pkg.sv
// caliptra_verilated_apb_pkg: shared widths, FSM states and request/response records for the APB driver
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

package caliptra_verilated_apb_pkg;
    localparam int APB_ADDR_W = `CALIPTRA_APB_ADDR_WIDTH;
    localparam int APB_DATA_W = `CALIPTRA_APB_DATA_WIDTH;
    localparam int APB_USER_W = `CALIPTRA_APB_USER_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_drv_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_USER_W-1:0] user;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;
endpackage

// File: rtl/caliptra_verilated_apb_driver_if.sv
// caliptra_verilated_apb_driver_if: harness request/response channel plus the APB3 bus of the driver
interface caliptra_verilated_apb_driver_if
    import caliptra_verilated_apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int USER_W = APB_USER_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [USER_W-1:0] req_user;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic [ADDR_W-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [USER_W-1:0] pauser;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_user, pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               paddr, pprot, psel, penable, pwrite, pwdata, pauser
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_user, pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               paddr, pprot, psel, penable, pwrite, pwdata, pauser
    );
endinterface

// File: rtl/caliptra_verilated_apb_driver_req_fifo.sv
// caliptra_verilated_req_fifo: synchronous request FIFO, pointers carry an extra wrap bit to tell full from empty
module caliptra_verilated_req_fifo
    import caliptra_verilated_apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  apb_req_t din,
    output logic     full,
    output logic     empty,
    output apb_req_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wp, r_rp;
    apb_req_t    r_mem [DEPTH];

    assign empty = r_wp == r_rp;
    assign full  = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
    assign head  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push && !full) begin
                r_mem[r_wp[AW-1:0]] <= din;
                r_wp                <= r_wp + 1'b1;
            end
            if (pop && !empty) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/caliptra_verilated_apb_driver.sv
// caliptra_verilated_apb_driver: plays queued harness requests out as APB3 transfers, one response each, with timeout
module caliptra_verilated_apb_driver
    import caliptra_verilated_apb_pkg::*;
#(
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int USER_W     = APB_USER_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 256
) (
    input logic core_clk,
    input logic rst,
    caliptra_verilated_apb_driver_if.master bus
);
    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    apb_drv_state_e r_state, w_next;
    apb_req_t       r_req, w_head, w_push_req;
    apb_rsp_t       r_rsp;
    logic           r_rsp_valid;
    logic [CW-1:0]  r_cnt;
    logic           w_full, w_empty, w_done, w_pop;

    assign w_push_req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata, user: bus.req_user};
    // an ACCESS cycle ends on pready or on its TIMEOUT-th cycle, whichever comes first
    assign w_done = r_state == ACCESS && (bus.pready || r_cnt == TO_LAST);
    assign w_pop  = !w_empty && (r_state == IDLE || w_done);

    caliptra_verilated_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (core_clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .pop   (w_pop),
        .din   (w_push_req),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_comb begin
        w_next = r_state;
        w_next = r_state == SETUP ? ACCESS :
                 (r_state == IDLE || w_done) ? (w_empty ? IDLE : SETUP) : r_state;
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= w_done;
            r_cnt       <= (r_state == ACCESS && !w_done) ? r_cnt + 1'b1 : '0;
            if (w_pop) r_req <= w_head;
            if (w_done) r_rsp <= '{rdata:   (bus.pready && !r_req.write) ? bus.prdata : '0,
                                   err:     bus.pready ? bus.pslverr : 1'b1,
                                   timeout: !bus.pready};
        end
    end

    assign bus.req_ready   = !w_full && !rst;
    assign bus.busy        = (!w_empty || r_state != IDLE) && !rst;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp.rdata;
    assign bus.rsp_err     = r_rsp.err;
    assign bus.rsp_timeout = r_rsp.timeout;
    assign bus.paddr       = ADDR_W'(r_req.addr);
    assign bus.pwrite      = r_req.write;
    assign bus.pwdata      = DATA_W'(r_req.wdata);
    assign bus.pauser      = USER_W'(r_req.user);
    assign bus.pprot       = 3'b000;
    assign bus.psel        = r_state != IDLE;
    assign bus.penable     = r_state == ACCESS;
endmodule

// File: tb/tb_caliptra_verilated_apb_driver.sv
// tb_caliptra_verilated_apb_driver: vector table plus scoreboard against a scripted APB slave
module tb_caliptra_verilated_apb_driver;
    import caliptra_verilated_apb_pkg::*;

    localparam int TIMEOUT = 8;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] user;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        logic [31:0] erdata;
        logic        eerr;
        logic        eto;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0, cyc = 0, n_rsp = 0;
    vec_t exp_q[$], slv_q[$];
    int   rsp_cyc[$];
    bit   in_acc = 1'b0;
    bit   prev_rv = 1'b0;
    vec_t s_cur;
    int   s_acc;
    vec_t tbl[8];

    caliptra_verilated_apb_driver_if bus();

    caliptra_verilated_apb_driver #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .core_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, int waits, logic [31:0] rd,
                                logic se, logic [31:0] erd, logic eerr, logic eto);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.user = a ^ 32'hA5A5_0000; v.waits = waits;
        v.rdata = rd; v.slverr = se; v.erdata = erd; v.eerr = eerr; v.eto = eto;
        return v;
    endfunction

    // scripted slave: ready after 'waits' wait states, prdata always driven so zeroing is visible
    initial forever begin
        @(negedge clk);
        if (bus.psel && bus.penable && !rst) begin
            if (!in_acc) begin
                chk("slave_has_xfer", slv_q.size() != 0, 1);
                if (slv_q.size() != 0) s_cur = slv_q.pop_front();
                s_acc  = 0;
                in_acc = 1'b1;
            end
            bus.pready  = s_acc == s_cur.waits;
            bus.prdata  = s_cur.rdata;
            bus.pslverr = (s_acc == s_cur.waits) && s_cur.slverr;
            if (s_acc == s_cur.waits || s_acc == TIMEOUT - 1) in_acc = 1'b0;
            s_acc++;
        end else begin
            bus.pready  = 1'b0;
            bus.prdata  = 32'h0;
            bus.pslverr = 1'b0;
        end
    end

    initial forever begin
        vec_t e;
        @(negedge clk);
        if (bus.rsp_valid) begin
            chk("rsp_single_cycle", prev_rv, 0);
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rsp_rdata@%0h", e.addr), bus.rsp_rdata, e.erdata);
                chk($sformatf("rsp_err@%0h", e.addr), bus.rsp_err, e.eerr);
                chk($sformatf("rsp_timeout@%0h", e.addr), bus.rsp_timeout, e.eto);
            end
            rsp_cyc.push_back(cyc);
            n_rsp++;
        end
        prev_rv = bus.rsp_valid;
    end

    task automatic send(input vec_t v);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_user  = v.user;
        while (!bus.req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_accept", bus.req_ready, 1);
        if (bus.req_ready) begin
            exp_q.push_back(v);
            slv_q.push_back(v);
        end else bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic watch_xfer(input vec_t v, output int sel, output int en);
        int n = 0;
        bit stable = 1'b1;
        logic [31:0] a, d, u;
        logic w;
        sel = 0;
        en  = 0;
        while (!bus.psel && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_start", bus.psel, 1);
        chk("xfer_setup", bus.penable, 0);
        chk("paddr", bus.paddr, v.addr);
        chk("pwrite", bus.pwrite, v.write);
        chk("pauser", bus.pauser, v.user);
        chk("pprot", bus.pprot, 0);
        a = bus.paddr; d = bus.pwdata; u = bus.pauser; w = bus.pwrite;
        while (bus.psel && !(en > 0 && !bus.penable) && sel < 200) begin
            sel++;
            if (bus.penable) en++;
            if (bus.paddr !== a || bus.pwdata !== d || bus.pauser !== u || bus.pwrite !== w) stable = 1'b0;
            @(negedge clk);
        end
        chk("apb_stable", stable, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, w2;
        int sel, en, n0, n;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_user = '0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;

        tbl[0] = mk(1, 32'h3000_0200, 32'h0102_0304, 0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
        tbl[1] = mk(0, 32'h3000_0204, 32'h0,         0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 0);
        tbl[2] = mk(0, 32'h3000_0208, 32'h0,         2, 32'h0BAD_C0DE, 1, 32'h0BAD_C0DE, 1, 0);
        tbl[3] = mk(1, 32'h3000_020C, 32'h1111_2222, 5, 32'h5555_5555, 1, 32'h0, 1, 0);
        tbl[4] = mk(0, 32'h3000_0210, 32'h0,         7, 32'h7777_0007, 0, 32'h7777_0007, 0, 0);
        tbl[5] = mk(0, 32'h3000_0214, 32'h0,         8, 32'h8888_8888, 0, 32'h0, 1, 1);
        tbl[6] = mk(1, 32'h3000_0218, 32'h9999_0000, 99, 32'h6666_6666, 1, 32'h0, 1, 1);
        tbl[7] = mk(0, 32'h3000_021C, 32'h0,         0, 32'h0000_0000, 0, 32'h0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);
        chk("post_rst_busy", bus.busy, 0);

        // single write: latency and psel width
        v = mk(1, 32'h3000_0100, 32'hDEAD_BEEF, 0, 32'hAAAA_5555, 0, 32'h0, 0, 0);
        send(v);
        idle();
        chk("lat_n_psel", bus.psel, 0);
        @(posedge clk); #1;
        chk("lat_n1_psel", bus.psel, 1);
        chk("lat_n1_penable", bus.penable, 0);
        chk("lat_n1_pwrite", bus.pwrite, 1);
        chk("lat_n1_paddr", bus.paddr, 32'h3000_0100);
        chk("lat_n1_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        chk("lat_n1_busy", bus.busy, 1);
        @(posedge clk); #1;
        chk("lat_n2_psel", bus.psel, 1);
        chk("lat_n2_penable", bus.penable, 1);
        chk("lat_n2_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_n3_rsp_valid", bus.rsp_valid, 1);
        chk("lat_n3_psel", bus.psel, 0);
        @(posedge clk); #1;
        chk("lat_n4_rsp_valid", bus.rsp_valid, 0);
        drain();

        for (int i = 0; i < 8; i++) send(tbl[i]);
        idle();
        drain();

        // read with three wait states
        v = mk(0, 32'h3000_0300, 32'h0, 3, 32'h1234_5678, 0, 32'h1234_5678, 0, 0);
        send(v);
        idle();
        watch_xfer(v, sel, en);
        chk("rdwait_psel_cycles", sel, 5);
        chk("rdwait_penable_cycles", en, 4);
        drain();

        // timeout followed by a queued write
        v  = mk(0, 32'h3000_0400, 32'h0, 99, 32'hBADB_AD00, 0, 32'h0, 1, 1);
        w2 = mk(1, 32'h3000_0404, 32'h4444_0404, 0, 32'h0, 0, 32'h0, 0, 0);
        send(v);
        send(w2);
        idle();
        watch_xfer(v, sel, en);
        chk("to_penable_cycles", en, TIMEOUT);
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_timeout", bus.rsp_timeout, 1);
        chk("to_next_psel", bus.psel, 1);
        chk("to_next_setup", bus.penable, 0);
        chk("to_next_paddr", bus.paddr, 32'h3000_0404);
        drain();

        // fill the FIFO behind a slow transfer, then drain back-to-back
        rsp_cyc.delete();
        send(mk(0, 32'h3000_0500, 32'h0, 6, 32'h0B0B_0B0B, 0, 32'h0B0B_0B0B, 0, 0));
        for (int i = 1; i <= 4; i++)
            send(mk(i[0], 32'h3000_0500 + 32'(i * 4), 32'hF000_0000 + 32'(i), 0, 32'hD000_0000 + 32'(i), 0,
                    i[0] ? 32'h0 : 32'hD000_0000 + 32'(i), 0, 0));
        idle();
        chk("fill_req_ready", bus.req_ready, 0);
        chk("fill_busy", bus.busy, 1);
        send(mk(0, 32'h3000_0514, 32'h0, 0, 32'hD000_0005, 0, 32'hD000_0005, 0, 0));
        idle();
        drain();
        chk("fill_rsp_count", rsp_cyc.size(), 6);
        if (rsp_cyc.size() == 6)
            for (int i = 1; i < 6; i++) chk($sformatf("b2b_spacing_%0d", i), rsp_cyc[i] - rsp_cyc[i-1], 2);

        // reset during the second ACCESS cycle with two requests queued
        send(mk(0, 32'h3000_0600, 32'h0, 6, 32'h6060_6060, 0, 32'h6060_6060, 0, 0));
        send(mk(1, 32'h3000_0604, 32'h6161_6161, 0, 32'h0, 0, 32'h0, 0, 0));
        send(mk(0, 32'h3000_0608, 32'h0, 0, 32'h6262_6262, 0, 32'h6262_6262, 0, 0));
        idle();
        n = 0;
        while (!(bus.psel && bus.penable) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rst_in_access", bus.penable, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        slv_q.delete();
        in_acc = 1'b0;
        n0 = n_rsp;
        @(posedge clk); #1;
        chk("mid_rst_psel", bus.psel, 0);
        chk("mid_rst_penable", bus.penable, 0);
        chk("mid_rst_paddr", bus.paddr, 0);
        chk("mid_rst_pwrite", bus.pwrite, 0);
        chk("mid_rst_pwdata", bus.pwdata, 0);
        chk("mid_rst_pauser", bus.pauser, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_busy", bus.busy, 0);
        chk("after_rst_req_ready", bus.req_ready, 1);
        repeat (20) @(negedge clk);
        chk("after_rst_no_rsp", n_rsp, n0);
        chk("after_rst_idle", bus.psel, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
